// File: rtl/uart_tx_fifo_if.sv
// Ready/valid handshake bundle between a byte producer, uart_tx_fifo and the transmitter.
// Build with UART_TX_FIFO_HWM_EN defined to add the high_water observation signal.
interface uart_tx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid;
  logic             data_out_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
`ifdef UART_TX_FIFO_HWM_EN
  logic [CW-1:0]    high_water;

  // master is the surrounding system (producer plus transmitter); slave is the FIFO
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, count, full, empty, high_water
  );
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, count, full, empty, high_water
  );
`else
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid, count, full, empty
  );
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid, count, full, empty
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding uart_transmitter; all flags come from registers.
// Optional UART_TX_FIFO_HWM_EN adds a high_water register of peak occupancy since reset.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_w, empty_w;
  logic             wr_fire, rd_fire;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // Fires look only at registered flags, so a blocked side never sees its partner's handshake.
  assign wr_fire = bus.data_in_valid  & ~full_w;
  assign rd_fire = bus.data_out_ready & ~empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no reset; a write coinciding with rst is dropped so reset wins cleanly.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out       = mem_q[rd_ptr_q];
  assign bus.data_out_valid = ~empty_w;
  assign bus.data_in_ready  = ~full_w;
  assign bus.count          = count_q;
  assign bus.full           = full_w;
  assign bus.empty          = empty_w;

`ifdef UART_TX_FIFO_HWM_EN
  logic [CW-1:0] high_water_q, high_water_d;

  assign high_water_d = (count_d > high_water_q) ? count_d : high_water_q;

  always_ff @(posedge clk) begin
    if (rst) high_water_q <= '0;
    else     high_water_q <= high_water_d;
  end

  assign bus.high_water = high_water_q;
`endif
endmodule
